// File: rtl/arcade_pause_ctrl.sv
// Pause merge and video-dim controller for arcade cores.
// The button toggle, external requests and OSD-open pause merge into one registered pause_cpu.
module arcade_pause_ctrl #(
  parameter int RW            = 4,
  parameter int GW            = 4,
  parameter int BW            = 4,
  parameter int NREQ          = 2,
  parameter int TICKS_PER_SEC = 12000000,
  parameter int DIM_SECS      = 10,
  parameter int DIM_SHIFT     = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic                  OSD_STATUS,
  input  logic [1:0]            options,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause_cpu,
  output logic                  user_paused,
  output logic                  dim_active
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = $clog2(DIM_SECS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SECS_MAX  = SW'(DIM_SECS);

  logic          btn_q;
  logic          btn_rise;
  logic          user_paused_next;
  logic          pause_src;
  logic          timer_run;
  logic [PW-1:0] presc;
  logic [SW-1:0] secs;
  logic [RW+GW+BW-1:0] rgb_dim;

  always_comb begin
    btn_rise         = user_button & ~btn_q;
    user_paused_next = user_paused ^ btn_rise;
    pause_src        = user_paused_next | (|pause_request) | (OSD_STATUS & options[0]);
    timer_run        = pause_cpu & options[1];
    rgb_dim          = {r >> DIM_SHIFT, g >> DIM_SHIFT, b >> DIM_SHIFT};
  end

  // btn_q follows the button even in reset so a press held across reset gives no edge.
  always_ff @(posedge clk_sys) begin
    btn_q <= user_button;
    if (reset) begin
      user_paused <= 1'b0;
      pause_cpu   <= 1'b0;
      presc       <= '0;
      secs        <= '0;
      dim_active  <= 1'b0;
      rgb_out     <= '0;
    end else begin
      user_paused <= user_paused_next;
      pause_cpu   <= pause_src;
      rgb_out     <= dim_active ? rgb_dim : {r, g, b};

      if (!timer_run) begin
        presc      <= '0;
        secs       <= '0;
        dim_active <= 1'b0;
      end else if (secs != SECS_MAX) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          secs  <= secs + 1'b1;
          if (secs + 1'b1 == SECS_MAX)
            dim_active <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arcade_pause_ctrl.sv
// Self-checking bench for arcade_pause_ctrl with a short dim timer (10 ticks/s, 3 s).
module tb_arcade_pause_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_button;
  logic [1:0]  pause_request;
  logic        OSD_STATUS;
  logic [1:0]  options;
  logic [3:0]  r, g, b;
  logic [11:0] rgb_out;
  logic        pause_cpu, user_paused, dim_active;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_rgb;

  arcade_pause_ctrl #(
    .RW(4), .GW(4), .BW(4), .NREQ(2),
    .TICKS_PER_SEC(10), .DIM_SECS(3), .DIM_SHIFT(1)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
    .pause_request(pause_request), .OSD_STATUS(OSD_STATUS), .options(options),
    .r(r), .g(g), .b(b), .rgb_out(rgb_out), .pause_cpu(pause_cpu),
    .user_paused(user_paused), .dim_active(dim_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; user_button = 0; pause_request = 0; OSD_STATUS = 0; options = 0;
    r = 0; g = 0; b = 0;
    tick(); tick();
    n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL reset_pause: got %b expected 0", pause_cpu); end
    n_cmp++; if (rgb_out !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h expected 000", rgb_out); end
    n_cmp++; if (user_paused !== 1'b0) begin n_err++; $display("FAIL reset_user: got %b expected 0", user_paused); end
    n_cmp++; if (dim_active !== 1'b0) begin n_err++; $display("FAIL reset_dim: got %b expected 0", dim_active); end
    reset = 0; r = 4'hA; g = 4'h5; b = 4'h3;
    exp_q.push_back(12'hA53);
    tick();
    exp_rgb = exp_q.pop_front();
    n_cmp++; if (rgb_out !== exp_rgb) begin n_err++; $display("FAIL video_pass: got %h expected %h", rgb_out, exp_rgb); end
  endtask

  task automatic test_button();
    user_button = 1;
    tick();
    n_cmp++; if (user_paused !== 1'b1) begin n_err++; $display("FAIL btn_toggle_on: got %b expected 1", user_paused); end
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL btn_pause_on: got %b expected 1", pause_cpu); end
    for (int i = 0; i < 19; i++) begin
      tick();
      n_cmp++; if (user_paused !== 1'b1) begin n_err++; $display("FAIL btn_held_%0d: got %b expected 1", i, user_paused); end
    end
    user_button = 0; tick();
    user_button = 1; tick();
    n_cmp++; if (user_paused !== 1'b0) begin n_err++; $display("FAIL btn_toggle_off: got %b expected 0", user_paused); end
    n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL btn_pause_off: got %b expected 0", pause_cpu); end
    user_button = 0; tick();
  endtask

  task automatic test_request();
    user_button = 1; tick(); user_button = 0;
    pause_request = 2'b10; tick();
    user_button = 1; tick();
    n_cmp++; if (user_paused !== 1'b0) begin n_err++; $display("FAIL req_untoggle: got %b expected 0", user_paused); end
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL req_hold: got %b expected 1", pause_cpu); end
    user_button = 0; tick();
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL req_hold2: got %b expected 1", pause_cpu); end
    pause_request = 2'b00; tick();
    n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL req_drop: got %b expected 0", pause_cpu); end
    // button edge and request rising together
    user_button = 1; pause_request = 2'b01; tick();
    n_cmp++; if (user_paused !== 1'b1) begin n_err++; $display("FAIL simul_toggle: got %b expected 1", user_paused); end
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL simul_pause: got %b expected 1", pause_cpu); end
    user_button = 0; tick();
    user_button = 1; tick();
    n_cmp++; if (user_paused !== 1'b0) begin n_err++; $display("FAIL simul_untoggle: got %b expected 0", user_paused); end
    user_button = 0; pause_request = 2'b00; tick();
    n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL simul_release: got %b expected 0", pause_cpu); end
  endtask

  task automatic test_osd();
    OSD_STATUS = 1; options = 2'b00; tick(); tick();
    n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL osd_disabled: got %b expected 0", pause_cpu); end
    options = 2'b01; tick();
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL osd_enabled: got %b expected 1", pause_cpu); end
    OSD_STATUS = 0; tick();
    n_cmp++; if (pause_cpu !== 1'b0) begin n_err++; $display("FAIL osd_closed: got %b expected 0", pause_cpu); end
    options = 2'b00; tick();
  endtask

  // Counts cycles from pause_cpu rising to dim_active rising, checking undimmed video meanwhile.
  task automatic measure_dim(input string tag);
    int rise;
    rise = -1;
    for (int i = 1; i <= 40 && rise < 0; i++) begin
      exp_q.push_back(12'hFFF);
      tick();
      exp_rgb = exp_q.pop_front();
      n_cmp++; if (rgb_out !== exp_rgb) begin n_err++; $display("FAIL %s_undim_%0d: got %h expected %h", tag, i, rgb_out, exp_rgb); end
      if (dim_active === 1'b1) rise = i;
    end
    n_cmp++; if (rise != 30) begin n_err++; $display("FAIL %s_dim_delay: got %0d expected 30", tag, rise); end
    exp_q.push_back(12'h777);
    tick();
    exp_rgb = exp_q.pop_front();
    n_cmp++; if (rgb_out !== exp_rgb) begin n_err++; $display("FAIL %s_dimmed: got %h expected %h", tag, rgb_out, exp_rgb); end
  endtask

  task automatic test_dim();
    r = 4'hF; g = 4'hF; b = 4'hF; options = 2'b10; pause_request = 2'b01;
    tick();
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL dim_pause: got %b expected 1", pause_cpu); end
    measure_dim("dim");
    pause_request = 2'b00;
    exp_q.push_back(12'h777); exp_q.push_back(12'h777); exp_q.push_back(12'hFFF);
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_rgb = exp_q.pop_front();
      n_cmp++; if (rgb_out !== exp_rgb) begin n_err++; $display("FAIL undim_rgb_%0d: got %h expected %h", i, rgb_out, exp_rgb); end
      if (i == 2) begin
        n_cmp++; if (dim_active !== 1'b0) begin n_err++; $display("FAIL undim_flag: got %b expected 0", dim_active); end
      end
    end
  endtask

  task automatic test_opt_drop();
    pause_request = 2'b01; options = 2'b10;
    tick();
    measure_dim("opt");
    options = 2'b00;
    exp_q.push_back(12'h777); exp_q.push_back(12'hFFF);
    tick();
    n_cmp++; if (dim_active !== 1'b0) begin n_err++; $display("FAIL opt_drop_flag: got %b expected 0", dim_active); end
    exp_rgb = exp_q.pop_front();
    n_cmp++; if (rgb_out !== exp_rgb) begin n_err++; $display("FAIL opt_drop_rgb1: got %h expected %h", rgb_out, exp_rgb); end
    tick();
    exp_rgb = exp_q.pop_front();
    n_cmp++; if (rgb_out !== exp_rgb) begin n_err++; $display("FAIL opt_drop_rgb2: got %h expected %h", rgb_out, exp_rgb); end
    pause_request = 2'b00; tick(); tick();
  endtask

  task automatic test_reset_mid();
    options = 2'b10; pause_request = 2'b01;
    tick();
    for (int i = 0; i < 15; i++) tick();
    reset = 1; tick();
    n_cmp++; if ({pause_cpu, user_paused, dim_active} !== 3'b000) begin n_err++; $display("FAIL mid_reset_flags: got %b expected 000", {pause_cpu, user_paused, dim_active}); end
    n_cmp++; if (rgb_out !== 12'h000) begin n_err++; $display("FAIL mid_reset_rgb: got %h expected 000", rgb_out); end
    reset = 0; tick();
    n_cmp++; if (pause_cpu !== 1'b1) begin n_err++; $display("FAIL mid_reassert: got %b expected 1", pause_cpu); end
    measure_dim("mid");
    pause_request = 2'b00; options = 2'b00; tick(); tick();
  endtask

  initial begin
    test_reset();
    test_button();
    test_request();
    test_osd();
    test_dim();
    test_opt_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
